// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: producer-side immediate input and
// consumer-side extended result output.
interface imm_extend_pipe_if #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_imm;
  logic [1:0]           in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_neg;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_neg
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_neg
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (sign/zero/upper/branch) with a small result FIFO.
// Define IMM_EXTEND_COUNT_EN to add the ext_count pop counter output.
module imm_extend_pipe #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned DEPTH     = 2
) (
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  imm_extend_pipe_if.slave bus
`ifdef IMM_EXTEND_COUNT_EN
  ,
  output logic [31:0]      ext_count
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PadW = OUT_WIDTH - IN_WIDTH;

  logic [OUT_WIDTH-1:0] mem_q [DEPTH];
  logic [OUT_WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [OUT_WIDTH-1:0] sign_ext;
  logic [OUT_WIDTH-1:0] ext_val;
  logic                 full, empty, push, pop;

  always_comb begin
    sign_ext = {{PadW{bus.in_imm[IN_WIDTH-1]}}, bus.in_imm};
    ext_val  = sign_ext;
    unique case (bus.in_mode)
      2'b00: ext_val = sign_ext;
      2'b01: ext_val = {{PadW{1'b0}}, bus.in_imm};
      2'b10: ext_val = {bus.in_imm, {PadW{1'b0}}};
      2'b11: ext_val = sign_ext << 2;
      default: ext_val = sign_ext;
    endcase
  end

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && bus.out_ready;

  // in_ready looks only at occupancy, so a full FIFO never pushes through.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.out_neg   = bus.out_data[OUT_WIDTH-1];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = ext_val;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef IMM_EXTEND_COUNT_EN
  logic [31:0] ext_count_q, ext_count_d;

  // Counts every pop, including one coinciding with flush; flush never clears it.
  always_comb begin
    ext_count_d = ext_count_q;
    if (pop) begin
      ext_count_d = ext_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_count_q <= '0;
    end else begin
      ext_count_q <= ext_count_d;
    end
  end

  assign ext_count = ext_count_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: scoreboard queue filled on accepted
// pushes and drained on pops, plus directed handshake, flush and reset checks.
module tb_imm_extend_pipe;

  logic clk;
  logic rst_n;
  logic flush;
`ifdef IMM_EXTEND_COUNT_EN
  logic [31:0] ext_count;
`endif

  imm_extend_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) bus ();

  imm_extend_pipe #(
    .IN_WIDTH (16),
    .OUT_WIDTH(32),
    .DEPTH    (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus)
`ifdef IMM_EXTEND_COUNT_EN
    ,
    .ext_count(ext_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] sb[$];
  int          n_checks;
  int          n_pass;
  int          pops;
  logic        acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [15:0] imm, input logic [1:0] mode);
    logic [31:0] s;
    s = imm[15] ? {16'hFFFF, imm} : {16'h0000, imm};
    case (mode)
      2'b00:   return s;
      2'b01:   return {16'h0000, imm};
      2'b10:   return {16'h0000, imm} * 32'd65536;
      default: return s * 32'd4;
    endcase
  endfunction

  // One clock: evaluate handshakes at the negedge, then return just after posedge.
  task automatic step();
    logic [31:0] exp_v;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        exp_v = sb.pop_front();
        check("data", bus.out_data, exp_v);
        check("neg", {31'b0, bus.out_neg}, {31'b0, exp_v[31]});
      end
      pops++;
    end
    if (flush) sb.delete();
    else if (acc) sb.push_back(ext_model(bus.in_imm, bus.in_mode));
    @(posedge clk);
    #1;
`ifdef IMM_EXTEND_COUNT_EN
    check("ext_count", ext_count, pops);
`endif
  endtask

  task automatic push(input logic [15:0] imm, input logic [1:0] mode);
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
    acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (acc) break;
    end
    if (!acc) check("push_timeout", {31'b0, acc}, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    pops     = 0;
    acc      = 1'b0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_imm    = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_neg", {31'b0, bus.out_neg}, 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Extension modes with a free-running consumer
    bus.out_ready = 1'b1;
    push(16'hFFFF, 2'b00);
    check("lat_valid", {31'b0, bus.out_valid}, 32'd1);
    check("lat_data", bus.out_data, 32'hFFFF_FFFF);
    push(16'h7FFF, 2'b00);
    push(16'h8000, 2'b01);
    push(16'h8000, 2'b10);
    push(16'h8000, 2'b11);
    check("branch_neg_data", bus.out_data, 32'hFFFE_0000);
    push(16'h0001, 2'b11);
    push(16'h1234, 2'b10);
    push(16'hABCD, 2'b01);
    repeat (2) step();
    check("idle_empty", {31'b0, bus.out_valid}, 32'd0);

    // Backpressure: third push must wait for a slot
    bus.out_ready = 1'b0;
    push(16'h0011, 2'b00);
    push(16'h8022, 2'b00);
    check("bp_full", {31'b0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_imm   = 16'h0033;
    bus.in_mode  = 2'b01;
    repeat (3) step();
    check("bp_hold", {31'b0, acc}, 32'd0);
    bus.out_ready = 1'b1;
    step();
    check("bp_ready_rise", {31'b0, bus.in_ready}, 32'd1);
    push(16'h0033, 2'b01);
    repeat (3) step();
    check("bp_drained", {31'b0, bus.out_valid}, 32'd0);

    // Concurrent push/pop at occupancy 1 across pointer wrap
    bus.in_valid = 1'b1;
    bus.in_imm   = 16'hF000;
    bus.in_mode  = 2'b00;
    step();
    for (int i = 1; i <= 10; i++) begin
      bus.in_imm  = 16'(i * 16'h1111);
      bus.in_mode = 2'(i);
      step();
      check("cc_valid", {31'b0, bus.out_valid}, 32'd1);
      check("cc_ready", {31'b0, bus.in_ready}, 32'd1);
    end
    bus.in_valid = 1'b0;
    repeat (2) step();

    // Flush with a full FIFO and a pending push
    bus.out_ready = 1'b0;
    push(16'h0101, 2'b00);
    push(16'h0202, 2'b00);
    bus.in_valid = 1'b1;
    bus.in_imm   = 16'h0D0D;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_valid", {31'b0, bus.out_valid}, 32'd0);
    check("fl_ready", {31'b0, bus.in_ready}, 32'd1);
    // Flush with one entry and an accepted push that must vanish
    push(16'h0E0E, 2'b00);
    bus.in_valid = 1'b1;
    bus.in_imm   = 16'h0F0F;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl2_valid", {31'b0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    repeat (4) step();
    check("sb_drain", sb.size(), 32'd0);

    // Async reset mid-cycle with a full FIFO
    bus.out_ready = 1'b0;
    push(16'h4444, 2'b00);
    push(16'h5555, 2'b00);
    check("pre_rst_full", {31'b0, bus.in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("arst_ready", {31'b0, bus.in_ready}, 32'd1);
    check("arst_data", bus.out_data, 32'd0);
`ifdef IMM_EXTEND_COUNT_EN
    check("arst_count", ext_count, 32'd0);
`endif
    sb.delete();
    pops = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    push(16'hFFFC, 2'b11);
    repeat (2) step();
    check("post_rst_empty", {31'b0, bus.out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the MIPS-32 datapath. It replaces the purely combinational extender.
- Accepts an IN_WIDTH immediate plus a mode select over a valid/ready handshake.
- Computes one of four extension modes (sign, zero, upper/LUI, branch offset) and buffers results in a small FIFO.
- Lets the decode stage run ahead of execute-stage stalls.

Parameters:
- IN_WIDTH, 16, width of the raw immediate.
- OUT_WIDTH, 32, width of the extended result; must be >= IN_WIDTH+2.
- DEPTH, 2, result FIFO entries; must be a power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous; discards all buffered entries
- in_valid  input  1  producer has a valid immediate
- in_ready  output  1  block can accept an immediate this cycle
- in_imm  input  IN_WIDTH  raw immediate
- in_mode  input  2  00 sign, 01 zero, 10 upper, 11 branch
- out_valid  output  1  head FIFO entry is valid
- out_ready  input  1  consumer accepts the head entry
- out_data  output  OUT_WIDTH  extended result at the FIFO head
- out_neg  output  1  MSB of out_data (sign of the result)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: FIFO empty, rd/wr pointers 0, in_ready=1, out_valid=0, out_data=0, out_neg=0.
- Push occurs when in_valid && in_ready at a rising edge. Pop occurs when out_valid && out_ready.
- Extension is computed combinationally on the input side and stored extended.
- Mode 00 (sign): {(OUT_WIDTH-IN_WIDTH){imm[MSB]}, imm}.
- Mode 01 (zero): {(OUT_WIDTH-IN_WIDTH){1'b0}, imm}.
- Mode 10 (upper): imm placed in the top IN_WIDTH bits, low bits zero.
- Mode 11 (branch): sign-extended value shifted left by 2. Bits shifted beyond OUT_WIDTH are dropped; the low 2 bits are 0.
- Latency: an entry pushed at edge k is visible as out_valid=1 with out_data after edge k; it is registered, with no combinational path from in_* to out_*.
- in_ready = !full. It depends only on the occupancy register, not on out_ready, so there is no push-through when full.
- out_valid = !empty. out_data and out_neg come from the head entry. out_data = 0 when empty.
- Simultaneous push and pop when neither full nor empty: both happen and occupancy is unchanged.
- Simultaneous push and pop when empty: push only, because out_valid=0.
- Full with pop: the pop frees a slot; in_ready rises the next cycle.
- Occupancy counter spans 0..DEPTH. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- flush (synchronous): at the edge, pointers and count clear. A push that coincides with flush is discarded. From the next cycle out_valid=0 and in_ready=1.
- rst_n asserted mid-operation: all state clears immediately and in-flight entries are lost.
- in_imm and in_mode are don't-care while in_valid=0.
- The producer holds in_imm and in_mode stable while in_valid=1 and in_ready=0.

Optional Feature:
- Macro: IMM_EXTEND_COUNT_EN.
- Defined: adds output port ext_count [31:0]. It increments by 1 on every pop and wraps 0xFFFFFFFF->0. It resets to 0 on rst_n. flush does not clear it.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Sign mode: push imm=16'hFFFF mode 00, out_ready=1 -> next cycle out_valid=1, out_data=32'hFFFFFFFF, out_neg=1. Push 16'h7FFF -> 32'h00007FFF, out_neg=0.
- Modes: push 16'h8000 in modes 01, 10 and 11 -> 32'h00008000, 32'h80000000 and 32'hFFFE0000 respectively. Push 16'h0001 mode 11 -> 32'h00000004.
- Backpressure: out_ready=0, push 3 values with DEPTH=2 -> in_ready=0 after 2 pushes and the third is held. Then out_ready=1 -> entries drain in order, the third is accepted, and no loss or duplication occurs.
- Concurrent push/pop at occupancy 1 -> occupancy stays 1, order is preserved, and pointer wrap-around is exercised over 8+ transfers.
- flush with 2 entries plus a simultaneous push -> next cycle out_valid=0, in_ready=1, and the pushed value never appears.
- Async reset: drop rst_n mid-cycle with a full FIFO -> out_valid=0 and in_ready=1 immediately, without waiting for clk. With IMM_EXTEND_COUNT_EN defined, 5 pops before reset give ext_count=5, then ext_count=0 after reset.
